// File: rtl/multi_pulse_core.sv
// N-channel pulse/PWM generator behind an MMIO slot (CTRL/PERIOD/HIGH/COUNT per channel).
// Define MULTI_PULSE_INVERT_EN to add a per-channel output invert flag in CTRL bit 3.
module multi_pulse_core #(
    parameter int unsigned N_CH   = 8,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic [N_CH-1:0]   pulse_out,
    output logic [N_CH-1:0]   busy
);
    localparam int unsigned CH_W = ADDR_W - 2;

    typedef enum logic {StIdle, StRun} state_e;

    logic [CH_W-1:0]  chan;
    logic [1:0]       reg_sel;
    logic [N_CH-1:0]  wsel, ctrl_wr;

    state_e           state_q [N_CH], state_d [N_CH];
    logic [CNT_W-1:0] period_q [N_CH], period_d [N_CH];
    logic [CNT_W-1:0] high_q [N_CH], high_d [N_CH];
    logic [CNT_W-1:0] count_q [N_CH], count_d [N_CH];
    logic [CNT_W-1:0] cnt_q [N_CH], cnt_d [N_CH];
    logic [CNT_W-1:0] per_act_q [N_CH], per_act_d [N_CH];
    logic [CNT_W-1:0] high_act_q [N_CH], high_act_d [N_CH];
    logic [CNT_W-1:0] rem_q [N_CH], rem_d [N_CH];
    logic [N_CH-1:0]  en_q, en_d, mode_q, mode_d, done_q, done_d;
    logic [N_CH-1:0]  pulse_q, pulse_d, busy_q, busy_d;
    logic [N_CH-1:0]  inv_q, inv_d;

    // Reads are side-effect free, so the read strobe carries no information here.
    logic unused_rd;
    assign unused_rd = rd;

    assign chan    = addr[ADDR_W-1:2];
    assign reg_sel = addr[1:0];

    always_comb begin
        wsel    = '0;
        ctrl_wr = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            wsel[i]    = cs & wr & (32'(chan) == 32'(i));
            ctrl_wr[i] = wsel[i] & (reg_sel == 2'd0);
        end
    end

`ifdef MULTI_PULSE_INVERT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) inv_q <= '0;
        else          inv_q <= inv_d;
    end

    always_comb begin
        inv_d = inv_q;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (ctrl_wr[i]) inv_d[i] = wr_data[3];
        end
    end
`else
    assign inv_q = '0;
    assign inv_d = '0;
`endif

    always_comb begin
        en_d    = en_q;
        mode_d  = mode_q;
        done_d  = done_q;
        pulse_d = '0;
        busy_d  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            state_d[i]    = state_q[i];
            period_d[i]   = period_q[i];
            high_d[i]     = high_q[i];
            count_d[i]    = count_q[i];
            cnt_d[i]      = cnt_q[i];
            per_act_d[i]  = per_act_q[i];
            high_act_d[i] = high_act_q[i];
            rem_d[i]      = rem_q[i];

            if (wsel[i]) begin
                unique case (reg_sel)
                    2'd0: begin
                        en_d[i]   = wr_data[0];
                        mode_d[i] = wr_data[1];
                    end
                    2'd1: period_d[i] = wr_data[CNT_W-1:0];
                    2'd2: high_d[i]   = wr_data[CNT_W-1:0];
                    2'd3: count_d[i]  = wr_data[CNT_W-1:0];
                endcase
            end

            if (state_q[i] == StRun) begin
                if (cnt_q[i] == per_act_q[i] - CNT_W'(1)) begin
                    cnt_d[i] = '0;
                    // A zero PERIOD written mid-run would stall the counter; keep the old one.
                    if (period_q[i] != '0) per_act_d[i] = period_q[i];
                    high_act_d[i] = high_q[i];
                    if (mode_q[i]) begin
                        if (rem_q[i] == CNT_W'(1)) begin
                            state_d[i] = StIdle;
                            done_d[i]  = 1'b1;
                        end else begin
                            rem_d[i] = rem_q[i] - CNT_W'(1);
                        end
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end

            // CTRL writes take priority over the free-running update above.
            if (ctrl_wr[i]) begin
                if (!wr_data[0]) begin
                    state_d[i] = StIdle;
                    cnt_d[i]   = '0;
                end else if (wr_data[2] && (period_q[i] != '0)) begin
                    cnt_d[i] = '0;
                    if (wr_data[1] && (count_q[i] == '0)) begin
                        state_d[i] = StIdle;
                        done_d[i]  = 1'b1;
                    end else begin
                        state_d[i]    = StRun;
                        per_act_d[i]  = period_q[i];
                        high_act_d[i] = high_q[i];
                        rem_d[i]      = count_q[i];
                        done_d[i]     = 1'b0;
                    end
                end
            end

            busy_d[i]  = (state_d[i] == StRun);
            pulse_d[i] = ((state_d[i] == StRun) && (cnt_d[i] < high_act_d[i])) ^ inv_d[i];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_q    <= '0;
            mode_q  <= '0;
            done_q  <= '0;
            pulse_q <= '0;
            busy_q  <= '0;
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i]    <= StIdle;
                period_q[i]   <= '0;
                high_q[i]     <= '0;
                count_q[i]    <= '0;
                cnt_q[i]      <= '0;
                per_act_q[i]  <= '0;
                high_act_q[i] <= '0;
                rem_q[i]      <= '0;
            end
        end else begin
            en_q    <= en_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
            busy_q  <= busy_d;
            for (int unsigned i = 0; i < N_CH; i++) begin
                state_q[i]    <= state_d[i];
                period_q[i]   <= period_d[i];
                high_q[i]     <= high_d[i];
                count_q[i]    <= count_d[i];
                cnt_q[i]      <= cnt_d[i];
                per_act_q[i]  <= per_act_d[i];
                high_act_q[i] <= high_act_d[i];
                rem_q[i]      <= rem_d[i];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (32'(chan) == 32'(i)) begin
                unique case (reg_sel)
                    2'd0: rd_data = {22'd0, done_q[i], busy_q[i], 4'd0, inv_q[i], 1'b0,
                                     mode_q[i], en_q[i]};
                    2'd1: rd_data = 32'(period_q[i]);
                    2'd2: rd_data = 32'(high_q[i]);
                    2'd3: rd_data = 32'(count_q[i]);
                endcase
            end
        end
    end

    assign pulse_out = pulse_q;
    assign busy      = busy_q;

endmodule
